// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the asynchronous FIFO halves.
// Pointers carry one extra wrap bit above the memory address.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_ADDR_WIDTH = 5;

    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[FIFO_ADDR_WIDTH] = g[FIFO_ADDR_WIDTH];
        for (int i = FIFO_ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this clock domain.
// Both resets clear every stage so a stale pointer never leaks through.
module ptr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             hw_rst,
    input  logic             sw_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else if (sw_rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i - 1];
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/read_modport.sv
// Read-domain half of the asynchronous FIFO: owns the read pointer, registers
// read data and derives empty/level flags from the synchronized write pointer.
module read_modport
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rclk,
    input  logic                  hw_rst,
    input  logic                  sw_rst,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rdempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);

    ptr_t rptr_bin;
    ptr_t wq_gray;
    ptr_t wq_bin;
    ptr_t rptr_next;
    ptr_t level_next;
    logic rd_ok;
    logic empty_next;
    logic aempty_next;

    ptr_sync #(
        .WIDTH  (ADDR_WIDTH + 1),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk    (rclk),
        .hw_rst (hw_rst),
        .sw_rst (sw_rst),
        .d      (wr_ptr_gray),
        .q      (wq_gray)
    );

    // Handshake: read_enable is a request; a word is consumed at a rising edge
    // only when read_enable & ~rdempty, and read_data holds it from that edge on.
    always_comb begin
        wq_bin      = gray2bin(wq_gray);
        rd_ok       = read_enable & ~rdempty;
        rptr_next   = rptr_bin + {{ADDR_WIDTH{1'b0}}, rd_ok};
        level_next  = wq_bin - rptr_next;
        empty_next  = (bin2gray(rptr_next) == wq_gray);
        aempty_next = (level_next <= {1'b0, aempty_value});
    end

    assign mem_raddr = rptr_bin[ADDR_WIDTH-1:0];

    always_ff @(posedge rclk or posedge hw_rst) begin
        if (hw_rst) begin
            rptr_bin        <= '0;
            rd_ptr_gray     <= '0;
            read_data       <= '0;
            fifo_read_count <= '0;
            rd_level        <= '0;
            rdempty         <= 1'b1;
            rd_almost_empty <= 1'b1;
            underflow       <= 1'b0;
        end else if (sw_rst) begin
            rptr_bin        <= '0;
            rd_ptr_gray     <= '0;
            read_data       <= '0;
            fifo_read_count <= '0;
            rd_level        <= '0;
            rdempty         <= 1'b1;
            rd_almost_empty <= 1'b1;
            underflow       <= 1'b0;
        end else begin
            rptr_bin        <= rptr_next;
            rd_ptr_gray     <= bin2gray(rptr_next);
            if (rd_ok) begin
                read_data       <= mem_rdata;
                fifo_read_count <= fifo_read_count + 1'b1;
            end
            // Flags look ahead to the post-read pointer so they are never a cycle stale.
            rdempty         <= empty_next;
            rd_level        <= level_next;
            rd_almost_empty <= aempty_next;
            underflow       <= read_enable & rdempty;
        end
    end

endmodule

// File: tb/tb_read_modport.sv
// Directed bench for read_modport: reset, underflow, fill/drain, full/wrap and
// soft reset, with read data checked against an expected queue.
module tb_read_modport;

    logic        rclk = 1'b0;
    logic        hw_rst = 1'b0;
    logic        sw_rst = 1'b0;
    logic        read_enable = 1'b0;
    logic [4:0]  aempty_value = 5'd0;
    logic [5:0]  wr_ptr_gray = 6'd0;
    logic [31:0] mem_rdata;
    logic [4:0]  mem_raddr;
    logic [5:0]  rd_ptr_gray;
    logic [31:0] read_data;
    logic        rdempty;
    logic        rd_almost_empty;
    logic        underflow;
    logic [5:0]  fifo_read_count;
    logic [5:0]  rd_level;

    logic [31:0] mem [32];
    logic [31:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [5:0]  tb_wptr = 6'd0;
    logic [5:0]  tb_rptr = 6'd0;
    logic [5:0]  tb_cnt  = 6'd0;

    read_modport #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (5),
        .SYNC_STAGES (2)
    ) dut (
        .rclk            (rclk),
        .hw_rst          (hw_rst),
        .sw_rst          (sw_rst),
        .read_enable     (read_enable),
        .aempty_value    (aempty_value),
        .wr_ptr_gray     (wr_ptr_gray),
        .mem_rdata       (mem_rdata),
        .mem_raddr       (mem_raddr),
        .rd_ptr_gray     (rd_ptr_gray),
        .read_data       (read_data),
        .rdempty         (rdempty),
        .rd_almost_empty (rd_almost_empty),
        .underflow       (underflow),
        .fifo_read_count (fifo_read_count),
        .rd_level        (rd_level)
    );

    // Clock and combinational memory model
    always #5 rclk = ~rclk;
    assign mem_rdata = mem[mem_raddr];

    function automatic logic [5:0] gray6(input logic [5:0] b);
        return b ^ {1'b0, b[5:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic set_wptr(input logic [5:0] w);
        tb_wptr     = w;
        wr_ptr_gray = gray6(w);
    endtask

    task automatic check_flags(input string tag);
        logic [5:0] lvl;
        lvl = tb_wptr - tb_rptr;
        check({tag, "_level"}, {26'd0, rd_level}, {26'd0, lvl});
        check({tag, "_empty"}, {31'd0, rdempty}, {31'd0, (lvl == 6'd0)});
        check({tag, "_aempty"}, {31'd0, rd_almost_empty}, {31'd0, (lvl <= {1'b0, aempty_value})});
        check({tag, "_count"}, {26'd0, fifo_read_count}, {26'd0, tb_cnt});
        check({tag, "_rgray"}, {26'd0, rd_ptr_gray}, {26'd0, gray6(tb_rptr)});
        check({tag, "_uflow"}, {31'd0, underflow}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, {31'd0, rdempty}, 32'd1);
        check({tag, "_aempty"}, {31'd0, rd_almost_empty}, 32'd1);
        check({tag, "_uflow"}, {31'd0, underflow}, 32'd0);
        check({tag, "_count"}, {26'd0, fifo_read_count}, 32'd0);
        check({tag, "_level"}, {26'd0, rd_level}, 32'd0);
        check({tag, "_rdata"}, read_data, 32'd0);
        check({tag, "_rgray"}, {26'd0, rd_ptr_gray}, 32'd0);
    endtask

    // Driver: n back-to-back reads, assuming the synchronized write pointer is settled.
    task automatic read_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            read_enable = 1'b1;
            check({tag, "_raddr"}, {27'd0, mem_raddr}, {27'd0, tb_rptr[4:0]});
            exp_q.push_back(mem[tb_rptr[4:0]]);
            step();
            tb_rptr = tb_rptr + 6'd1;
            tb_cnt  = tb_cnt + 6'd1;
            if (exp_q.size() == 0) begin
                check({tag, "_qempty"}, 32'd1, 32'd0);
            end else begin
                check({tag, "_rdata"}, read_data, exp_q.pop_front());
            end
            check_flags(tag);
        end
        read_enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA0 + i;

        // Async reset with no clock edge
        #2 hw_rst = 1'b1;
        #1 check_reset_vals("hw_rst_async");
        step();
        hw_rst = 1'b0;
        step();
        check_flags("idle");

        // Single-cycle underflow on an empty FIFO
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
        check("uflow_pulse", {31'd0, underflow}, 32'd1);
        check("uflow_count", {26'd0, fifo_read_count}, 32'd0);
        check("uflow_rgray", {26'd0, rd_ptr_gray}, 32'd0);
        step();
        check("uflow_clear", {31'd0, underflow}, 32'd0);

        // Fill 4 words, empty must lag the synchronizer
        aempty_value = 5'd2;
        set_wptr(6'd4);
        step();
        step();
        check("fill_lag_empty", {31'd0, rdempty}, 32'd1);
        step();
        check_flags("fill");
        read_n(4, "drain4");

        // Async reset mid-run, then full FIFO and pointer wrap
        #3 hw_rst = 1'b1;
        #1 check_reset_vals("hw_rst_mid");
        tb_rptr = 6'd0;
        tb_cnt  = 6'd0;
        set_wptr(6'd0);
        #2 hw_rst = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        aempty_value = 5'd0;
        set_wptr(6'd32);
        step();
        step();
        step();
        check("full_level", {26'd0, rd_level}, 32'd32);
        check_flags("full");
        read_n(32, "drain32");
        set_wptr(6'd40);
        step();
        step();
        step();
        check_flags("wrap_fill");
        read_n(8, "wrap8");
        check("wrap_rgray", {26'd0, rd_ptr_gray}, {26'd0, gray6(6'd40)});
        check("wrap_count", {26'd0, fifo_read_count}, 32'd40);

        // Consecutive underflow cycles keep the flag high
        read_enable = 1'b1;
        step();
        check("uflow2_a", {31'd0, underflow}, 32'd1);
        step();
        check("uflow2_b", {31'd0, underflow}, 32'd1);
        check("uflow2_count", {26'd0, fifo_read_count}, 32'd40);
        read_enable = 1'b0;
        step();
        check("uflow2_clear", {31'd0, underflow}, 32'd0);

        // Soft reset wins over a pending read
        aempty_value = 5'd1;
        set_wptr(6'd45);
        step();
        step();
        step();
        check_flags("pre_sw");
        read_enable = 1'b1;
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        read_enable = 1'b0;
        check_reset_vals("sw_rst");
        tb_rptr = 6'd0;
        tb_cnt  = 6'd0;
        set_wptr(6'd3);
        step();
        step();
        check("sw_lag_empty", {31'd0, rdempty}, 32'd1);
        step();
        check_flags("sw_reacq");
        read_n(3, "sw_read3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
